// File: rtl/subtractor_pkg.sv
// subtractor_pkg
// Shared definitions for the subtractor family: the controller state
// encoding and the default operand width. Other subtractor blocks import
// this package so state values stay consistent across the family.
package subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
// One-bit full subtractor built from two half subtractors and an OR:
// the first stage computes a - b, the second subtracts the incoming borrow.
// At most one of the two stages can borrow, so OR-ing them gives bout.
// Ports:
//   a, b  : input  operand bits (a is minuend)
//   bin   : input  borrow in
//   diff  : output difference bit
//   bout  : output borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .a    (a),
    .b    (b),
    .diff (d1),
    .bout (b1)
  );

  half_subtractor u_hs1 (
    .a    (d1),
    .b    (bin),
    .diff (diff),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// half_subtractor
// One-bit half subtractor: diff = a - b, bout set when a borrow is needed.
// Ports:
//   a, b  : input  operand bits (a is minuend)
//   diff  : output difference bit
//   bout  : output borrow out
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b;
  assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial subtractor controller. Latches a and b on an accepted start,
// then feeds one full_subtractor cell LSB first for WIDTH cycles, carrying
// the borrow in a register. The difference is assembled in a shift register
// and copied to the output registers on the last shift, together with the
// final borrow, followed by a one-cycle done pulse.
// Ports:
//   clk        : input  rising-edge clock
//   rst        : input  asynchronous active-high reset
//   start      : input  request, only looked at in IDLE
//   a, b       : input  WIDTH-bit minuend / subtrahend, captured on accept
//   busy       : output high while shifting
//   done       : output one-cycle pulse when diff/borrow_out are updated
//   diff       : output registered a - b mod 2^WIDTH
//   borrow_out : output final borrow (a < b unsigned)
//   state_dbg  : output current FSM state, for observation only
//
// Handshake: start is a level request; the controller accepts it on any
// rising edge where it is in IDLE and start is high. Requests in SHIFT or
// DONE are dropped, not queued. done marks the single cycle in which a new
// result first appears; diff/borrow_out then hold until the next done.
module serial_subtractor_ctrl
  import subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output state_t           state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   diff_sr_q, diff_sr_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               br_q, br_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic cell_d;
  logic cell_bo;

  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .diff (cell_d),
    .bout (cell_bo)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    diff_d    = diff_q;
    br_d      = br_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d    = a;
          b_sr_d    = b;
          diff_sr_d = '0;
          br_d      = 1'b0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // New bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB.
        diff_sr_d = {cell_d, diff_sr_q[WIDTH-1:1]};
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        br_d      = cell_bo;
        cnt_d     = cnt_q + CNT_W'(1);
        // Exit on the last bit so cnt never has to reach WIDTH.
        if (cnt_q == CNT_LAST) begin
          diff_d   = {cell_d, diff_sr_q[WIDTH-1:1]};
          borrow_d = cell_bo;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      diff_q    <= '0;
      br_q      <= 1'b0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      diff_q    <= diff_d;
      br_q      <= br_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
    end
  end

  // Status outputs decode the state register directly, so they are glitch-free
  // and busy/done are mutually exclusive by construction.
  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Testbench for serial_subtractor_ctrl (WIDTH = 8).
module tb_serial_subtractor_ctrl;
  import subtractor_pkg::*;

  localparam int W = 8;
  localparam int BUDGET = 40;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  state_t       state_dbg;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a_in),
    .b          (b_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: {borrow, diff} = {0,a} - {0,b}.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // ---------------- driver ----------------
  // Drives one request (all driving and sampling on negedge) and waits for
  // done. lat counts edges from the accepting edge (inclusive) to done,
  // busy_cnt counts cycles with busy high, overlap counts busy&done cycles.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int mid_start_at,
                       output int lat, output int busy_cnt,
                       output logic [W-1:0] hold_diff_bad);
    logic [W-1:0] prev_diff;
    prev_diff = diff;
    hold_diff_bad = '0;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom_range(0, 255);
    b_in  = $urandom_range(0, 255);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < BUDGET) begin
      if (busy) busy_cnt++;
      hold_diff_bad |= (diff ^ prev_diff);
      start = (lat == mid_start_at);
      if (lat == mid_start_at) begin
        a_in = 8'h01;
        b_in = 8'h01;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: done not seen within %0d cycles", BUDGET);
    end
    check("busy_done_excl", {31'd0, busy & done}, 32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_bo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, bc;
    logic [W-1:0] hold_bad;
    logic [W:0] exp;
    int done_t[$];
    logic [W-1:0] ops_a[3];
    logic [W-1:0] ops_b[3];
    int t;
    int seen_done;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
    vecs[7] = '{8'hAA, 8'h55, 8'h55, 1'b0};

    // Reset state (reset asserted at time 0, before any edge).
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow_out}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, -1, lat, bc, hold_bad);
      check($sformatf("vec%0d_diff", i), {24'd0, diff}, {24'd0, vecs[i].exp_diff});
      check($sformatf("vec%0d_borrow", i), {31'd0, borrow_out}, {31'd0, vecs[i].exp_bo});
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_busy_cycles", i), bc, 8);
      check($sformatf("vec%0d_diff_hold", i), {24'd0, hold_bad}, 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d_diff_after", i), {24'd0, diff}, {24'd0, vecs[i].exp_diff});
    end

    // Start pulsed mid-SHIFT is ignored; diff holds previous value until done.
    do_op(8'hA5, 8'h5A, 3, lat, bc, hold_bad);
    check("mid_start_diff", {24'd0, diff}, 32'h4B);
    check("mid_start_borrow", {31'd0, borrow_out}, 32'd0);
    check("mid_start_hold", {24'd0, hold_bad}, 32'd0);
    check("mid_start_latency", lat, 9);
    repeat (3) @(negedge clk);
    check("mid_start_not_queued", {31'd0, busy}, 32'd0);

    // Start held high for three operations.
    ops_a[0] = 8'h10; ops_b[0] = 8'h01;
    ops_a[1] = 8'h01; ops_b[1] = 8'h10;
    ops_a[2] = 8'hC3; ops_b[2] = 8'h3C;
    a_in = ops_a[0]; b_in = ops_b[0]; start = 1'b1;
    t = 0;
    seen_done = 0;
    while (seen_done < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (t == 1) begin a_in = ops_a[1]; b_in = ops_b[1]; end
      if (t == 11) begin a_in = ops_a[2]; b_in = ops_b[2]; end
      if (t == 21) begin a_in = 8'h00; b_in = 8'hFF; end
      check("held_busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        exp = ref_sub(ops_a[seen_done], ops_b[seen_done]);
        check($sformatf("held%0d_result", seen_done), {23'd0, borrow_out, diff}, {23'd0, exp});
        done_t.push_back(t);
        seen_done++;
      end
    end
    start = 1'b0;
    if (seen_done != 3) begin
      checks++;
      errors++;
      $display("FAIL held_timeout: saw %0d of 3 done pulses", seen_done);
    end else begin
      check("held_first_done", done_t[0], 9);
      check("held_spacing01", done_t[1] - done_t[0], 10);
      check("held_spacing12", done_t[2] - done_t[1], 10);
    end
    repeat (3) @(negedge clk);

    // Reset 4 cycles into SHIFT.
    a_in = 8'h77; b_in = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {24'd0, diff}, 32'd0);
    check("midrst_borrow", {31'd0, borrow_out}, 32'd0);
    check("midrst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("midrst_no_done", seen_done, 0);
    do_op(8'h10, 8'h20, -1, lat, bc, hold_bad);
    check("post_rst_diff", {24'd0, diff}, 32'hF0);
    check("post_rst_borrow", {31'd0, borrow_out}, 32'd1);
    check("post_rst_latency", lat, 9);
    @(negedge clk);

    // Random regression against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      exp_q.push_back(ref_sub(ra, rb));
      do_op(ra, rb, -1, lat, bc, hold_bad);
      exp = exp_q.pop_front();
      check("rand_result", {23'd0, borrow_out, diff}, {23'd0, exp});
      @(negedge clk);
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial subtractor controller. It latches two WIDTH-bit operands on a start pulse and sequences a single 1-bit full-subtractor cell over WIDTH clock cycles, LSB first, carrying the borrow between cycles. It then presents the registered difference and final borrow with a one-cycle done pulse. It sits beside the half/full subtractor cells and trades throughput for area when a wide parallel subtractor is not justified.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; diff/borrow_out are valid from this cycle on.
- diff  output  WIDTH  registered a − b mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned).

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE, start=1:**
  - Load a_sr←a and b_sr←b.
  - Clear the borrow register br←0, the bit counter cnt←0, and diff_sr←0.
  - Go to SHIFT.
- **IDLE, start=0:** stay in IDLE. All outputs hold.
- **SHIFT, each edge:**
  - Bit cell computes d = a_sr[0] ^ b_sr[0] ^ br and bo = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - diff_sr ← {d, diff_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1; br←bo; cnt←cnt+1.
  - On the edge where cnt = WIDTH−1: also load diff←{d, diff_sr[WIDTH-1:1]} and borrow_out←bo, then go to DONE.
- **DONE:** done=1 for exactly one cycle, then unconditionally go to IDLE.
- **start while busy:** start asserted in SHIFT or DONE is ignored and not queued.
- **Output stability:** diff and borrow_out change only on the SHIFT→DONE edge. They hold their values through IDLE and through the next operation until that operation's DONE.
- **cnt width:** $clog2(WIDTH) bits. It never wraps, because the exit happens at WIDTH−1.
- **Operand capture:** a and b are don't-care outside the accepting edge.

## Timing
- **Reset values:**
  - State IDLE; busy=0, done=0, diff=0, borrow_out=0.
  - a_sr, b_sr, diff_sr, br, cnt all 0.
- **Latency:** start accepted at edge E0; busy=1 after E0 through edge E(WIDTH); done=1 in the cycle after E(WIDTH). That is WIDTH+1 cycles from accept to done. A new start is accepted no earlier than the cycle after done.
- **Throughput:** one operation every WIDTH+2 cycles when start is held high continuously.
- **busy and done:** never high in the same cycle.
- **Reset mid-operation:** rst asserted in any state immediately (asynchronously) forces all reset values, including diff and borrow_out. No done pulse is produced for the aborted operation. Start is re-sampled on the first edge after rst deasserts.

## Structure
- A shared package/header `subtractor_pkg` holds the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH. Other subtractor-family blocks reuse it.
- Sub-module `full_subtractor` (a, b, bin → diff, bout) is instantiated once as the bit cell, built from two half_subtractor instances plus an OR. The controller holds only registers and the FSM.
- Expected size: roughly 150–200 lines of RTL.

## Test plan
All cases use WIDTH=8.
- 0x05 − 0x03: after start, done arrives exactly 9 cycles later with diff=0x02, borrow_out=0; busy is high for exactly 8 cycles.
- 0x03 − 0x05 → diff=0xFE, borrow_out=1. 0x00 − 0x01 → diff=0xFF, borrow_out=1. 0xFF − 0x01 → diff=0xFE, borrow_out=0. 0x00 − 0x00 → diff=0x00, borrow_out=0.
- Start a = 0xA5, b = 0x5A, then pulse start again with a = 0x01, b = 0x01 mid-SHIFT. The second start is ignored and the result is diff=0x4B, borrow_out=0. diff holds its previous value until DONE.
- Start held high for 3 operations: done pulses are spaced 10 cycles apart and each result matches the operands sampled at its own accepting edge.
- Assert rst 4 cycles into SHIFT: all outputs go to 0 immediately with no done pulse. After release, 0x10 − 0x20 completes with diff=0xF0, borrow_out=1.
- Random regression: 1000 random a/b pairs checked against the reference model {borrow_out, diff} = {1'b0, a} − {1'b0, b}.
